instruction_control_unit: RTL

Control unit directly downstream of the video-processor instruction decoder. It consumes the decoded opcode and field buses, sequences the write into the correct target (sprite register bank, sprite memory, background memory or co-processor instruction memory), and drives `new_instruction` back to the decoder so that only one instruction is in flight at a time. Register-bank writes are deferred to a screen-safe window, with a bounded wait.

---
 rtl/instruction_control_unit.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/instruction_control_unit.sv
// ---------------------------------------------------------------------------
// instruction_control_unit
//
// Purpose: sits directly after the video-processor instruction decoder. It
// takes one decoded instruction at a time and sequences its write into one
// target: the sprite register bank, sprite memory, background memory or
// co-processor instruction memory. Register-bank writes wait for a
// screen-safe window, and the wait is bounded.
//
// Ports:
//   clk_en               clock, rising edge
//   reset                asynchronous, active-low
//   opcode               decoded opcode (0..3 valid, 4'hF = none)
//   register_in/data_in  register index/data (op 0), cop instruction (op 3)
//   sprite_address       sprite memory address (op 1)
//   background_address   background memory address (op 2)
//   memory_data          colour word (ops 1, 2)
//   cop_address          co-processor memory address (op 3)
//   screen_safe          high while the register bank may be updated
//   new_instruction      high in IDLE: the decoder may present the next op
//   reg_* / spr_* / bg_* / cop_*  write ports, addr/data zero when idle
//   instr_count          completed instructions (wraps)
//   safe_timeout         sticky flag: a register write was forced
// ---------------------------------------------------------------------------
module instruction_control_unit #(
    parameter int MEM_WR_CYCLES = 2,
    parameter int SAFE_TIMEOUT  = 1023
) (
    input  logic        clk_en,
    input  logic        reset,
    input  logic [3:0]  opcode,
    input  logic [4:0]  register_in,
    input  logic [31:0] data_in,
    input  logic [13:0] sprite_address,
    input  logic [12:0] background_address,
    input  logic [8:0]  memory_data,
    input  logic [3:0]  cop_address,
    input  logic        screen_safe,
    output logic        new_instruction,
    output logic        reg_wr,
    output logic [4:0]  reg_addr,
    output logic [31:0] reg_data,
    output logic        spr_wr,
    output logic [13:0] spr_addr,
    output logic [8:0]  spr_data,
    output logic        bg_wr,
    output logic [12:0] bg_addr,
    output logic [8:0]  bg_data,
    output logic        cop_wr,
    output logic [3:0]  cop_addr,
    output logic [31:0] cop_data,
    output logic [15:0] instr_count,
    output logic        safe_timeout
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_SAFE = 2'd1;
    localparam logic [1:0] WRITE     = 2'd2;
    localparam logic [1:0] DONE      = 2'd3;

    localparam int WAIT_W  = $clog2(SAFE_TIMEOUT + 1);
    localparam int WRITE_W = $clog2(MEM_WR_CYCLES + 1);

    logic [1:0]         state;
    logic [1:0]         next_state;
    logic [1:0]         op_q;
    logic [4:0]         reg_q;
    logic [31:0]        data_q;
    logic [13:0]        spr_q;
    logic [12:0]        bg_q;
    logic [8:0]         mem_q;
    logic [3:0]         cop_q;
    logic [WAIT_W-1:0]  wait_count;
    logic [WRITE_W-1:0] write_count;
    logic               op_valid;
    logic               wait_done;
    logic               mem_op;
    logic               write_done;

    assign op_valid   = (opcode <= 4'd3);
    // The counter holds k-1 during the k-th WAIT_SAFE cycle, so a forced
    // write leaves after exactly SAFE_TIMEOUT cycles.
    assign wait_done  = (wait_count == WAIT_W'(SAFE_TIMEOUT - 1));
    assign mem_op     = (op_q == 2'd1) || (op_q == 2'd2);
    assign write_done = (write_count == WRITE_W'(MEM_WR_CYCLES - 1));

    // Next-state decode; opcodes other than 0..3 leave the unit idle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (op_valid)
                    next_state = (opcode == 4'd0) ? WAIT_SAFE : WRITE;
            end
            WAIT_SAFE: begin
                if (screen_safe || wait_done)
                    next_state = WRITE;
            end
            WRITE: begin
                // Memory writes hold their enable for several cycles; the
                // register bank and co-processor take a single cycle.
                if (!mem_op || write_done)
                    next_state = DONE;
            end
            default: next_state = IDLE;
        endcase
    end

    // State register; an asynchronous reset aborts any write in progress.
    always_ff @(posedge clk_en or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Snapshot of the instruction, so bus changes while busy are ignored.
    always_ff @(posedge clk_en or negedge reset) begin
        if (!reset) begin
            op_q   <= 2'd0;
            reg_q  <= 5'd0;
            data_q <= 32'd0;
            spr_q  <= 14'd0;
            bg_q   <= 13'd0;
            mem_q  <= 9'd0;
            cop_q  <= 4'd0;
        end else if (state == IDLE && op_valid) begin
            op_q   <= opcode[1:0];
            reg_q  <= register_in;
            data_q <= data_in;
            spr_q  <= sprite_address;
            bg_q   <= background_address;
            mem_q  <= memory_data;
            cop_q  <= cop_address;
        end
    end

    // Per-state cycle counters, cleared whenever their state is left so
    // that each visit starts from zero.
    always_ff @(posedge clk_en or negedge reset) begin
        if (!reset) begin
            wait_count  <= '0;
            write_count <= '0;
        end else begin
            if (state == WAIT_SAFE && next_state == WAIT_SAFE)
                wait_count <= wait_count + 1'b1;
            else
                wait_count <= '0;
            if (state == WRITE && next_state == WRITE)
                write_count <= write_count + 1'b1;
            else
                write_count <= '0;
        end
    end

    // Completion counter and sticky timeout flag. A screen-safe window that
    // arrives on the timeout cycle itself counts as a normal write.
    always_ff @(posedge clk_en or negedge reset) begin
        if (!reset) begin
            instr_count  <= 16'd0;
            safe_timeout <= 1'b0;
        end else begin
            if (state == DONE)
                instr_count <= instr_count + 16'd1;
            if (state == WAIT_SAFE && wait_done && !screen_safe)
                safe_timeout <= 1'b1;
        end
    end

    // Write ports decode straight from state, so reset drops them at once.
    always_comb begin
        new_instruction = (state == IDLE);
        reg_wr   = (state == WRITE) && (op_q == 2'd0);
        spr_wr   = (state == WRITE) && (op_q == 2'd1);
        bg_wr    = (state == WRITE) && (op_q == 2'd2);
        cop_wr   = (state == WRITE) && (op_q == 2'd3);
        reg_addr = reg_wr ? reg_q  : 5'd0;
        reg_data = reg_wr ? data_q : 32'd0;
        spr_addr = spr_wr ? spr_q  : 14'd0;
        spr_data = spr_wr ? mem_q  : 9'd0;
        bg_addr  = bg_wr  ? bg_q   : 13'd0;
        bg_data  = bg_wr  ? mem_q  : 9'd0;
        cop_addr = cop_wr ? cop_q  : 4'd0;
        cop_data = cop_wr ? data_q : 32'd0;
    end

endmodule
